jtag_uart_arbiter: RTL and testbench
====================================

# jtag_uart_arbiter

Sequencer and arbiter for the JTAG UART Avalon slave port. Shares the single slave between a receive poller, which feeds the host byte stream to the frame/command parser, and a transmit requester, which sends status/ack bytes back to the host. Write flow control uses the UART control register's WSPACE field. The block replaces the free-running always-read master and is the only block driving the slave.

## Interface
Parameters:
- RX_BURST_MAX, 8: max consecutive RX reads while TX is pending before TX is granted (range 1..255).

Ports:
- iCLK  in  1  system clock; one clock domain.
- iRST  in  1  reset, synchronous, active-high.
- oJTAG_SLAVE_ADDR  out  1  0 = DATA register, 1 = CONTROL register.
- oJTAG_SLAVE_RDREQ  out  1  Avalon read request.
- iJTAG_SLAVE_RDDATA  in  32  Avalon read data; valid in the cycle WAIT is low.
- oJTAG_SLAVE_WRREQ  out  1  Avalon write request.
- oJTAG_SLAVE_WRDATA  out  32  Avalon write data.
- iJTAG_SLAVE_WAIT  in  1  Avalon waitrequest.
- iRX_HOLD  in  1  parser backpressure; high = do not start new RX reads.
- oRX_DATA  out  8  received byte.
- oRX_VALID  out  1  one-cycle pulse; oRX_DATA is valid.
- iTX_REQ  in  1  transmit request; held high until oTX_ACK.
- iTX_DATA  in  8  byte to send; stable while iTX_REQ is high.
- oTX_ACK  out  1  one-cycle pulse; byte written to the UART.

## Operation
- States: ST_IDLE, ST_RD_DATA, ST_RD_CTRL, ST_WR_DATA.
- Avalon outputs decode from the registered state. ST_RD_DATA: ADDR=0, RDREQ=1. ST_RD_CTRL: ADDR=1, RDREQ=1. ST_WR_DATA: ADDR=0, WRREQ=1, WRDATA={24'd0, tx_byte}. ST_IDLE: all requests 0.
- A transfer completes in the first cycle of a request state where WAIT=0. RDREQ and WRREQ are never high together. Address and data stay stable while a request is high.
- ST_IDLE grant decision:
  - rx_want = !iRX_HOLD.
  - tx_want = iTX_REQ && !oTX_ACK. This blocks a double send in the ack cycle.
  - TX is granted if tx_want && (!rx_want || burst_cnt >= RX_BURST_MAX). Otherwise RX is granted if rx_want. Otherwise the block stays in ST_IDLE.
- RX grant: go to ST_RD_DATA.
  - On completion, register RDDATA[7:0] into oRX_DATA.
  - oRX_VALID = RDDATA[15] (RVALID).
  - burst_cnt increments, saturating at 255.
  - If RVALID=0, burst_cnt is set to RX_BURST_MAX, so an empty UART yields to TX at once.
  - Return to ST_IDLE.
- TX grant:
  - tx_byte is latched from iTX_DATA and burst_cnt is cleared.
  - If wspace != 0, go to ST_WR_DATA; otherwise go to ST_RD_CTRL.
- ST_RD_CTRL completion: wspace = RDDATA[31:16].
  - If nonzero, go to ST_WR_DATA.
  - If zero, go to ST_IDLE with burst_cnt already 0, so RX gets RX_BURST_MAX turns before the next retry (no RX starvation).
- ST_WR_DATA completion: wspace decrements by 1, oTX_ACK pulses, return to ST_IDLE.
- wspace is a 16-bit cache. It never underflows: a write is only entered with wspace ≥ 1.

## Timing
- Reset values: state ST_IDLE, all Avalon outputs 0, WRDATA 0, oRX_DATA 0x00, oRX_VALID 0, oTX_ACK 0, burst_cnt 0, wspace 0.
- Reset mid-transfer: the request drops at the reset edge and any in-flight byte is discarded. This is accepted behaviour.
- Request is asserted the cycle after the grant. Minimum RX period is 2 cycles per byte (ST_IDLE + ST_RD_DATA with WAIT=0).
- oRX_VALID and oRX_DATA are asserted in the cycle after read completion and last exactly one cycle.
- oTX_ACK is asserted in the cycle after write completion and lasts one cycle.
- TX latency from iTX_REQ to ack, with WAIT=0 and idle RX:
  - 3 cycles with cached wspace.
  - 4 cycles when a CONTROL read is needed.
- iRX_HOLD is sampled only in ST_IDLE. A read already issued completes, and its byte is delivered even if iRX_HOLD has risen.
- If rx_want and tx_want occur together with burst_cnt < RX_BURST_MAX, RX wins.

## Configuration
- JTAG_UART_ARB_STATS_EN defined: adds output ports oSTAT_RX_BYTES[15:0] and oSTAT_TX_STALLS[15:0].
  - oSTAT_RX_BYTES counts oRX_VALID pulses.
  - oSTAT_TX_STALLS counts CONTROL reads that return WSPACE=0.
  - Both wrap at 16 bits and reset to 0.
- Undefined: these ports and counters do not exist. Core behaviour is identical either way.

## Structure
- Shared package/header jtag_uart_pkg holds:
  - state encodings;
  - register addresses JTAG_DATA_ADDR=0 and JTAG_CTRL_ADDR=1;
  - RVALID bit index 15;
  - WSPACE field [31:16].
- One sub-module, jtag_uart_arb_stats, holds the two counters and is instantiated only under JTAG_UART_ARB_STATS_EN.

## Test plan
- Reset, then WAIT=0 and RDDATA=0x0000_8041 every read, iRX_HOLD=0 → oRX_VALID pulses every 2nd cycle with oRX_DATA=0x41.
- RDDATA bit15=0 (empty) → RDREQ keeps polling and oRX_VALID stays 0. Assert iTX_REQ with 0x5A and CONTROL reads returning WSPACE=0x0040 → one CONTROL read, one write of 0x0000_005A, oTX_ACK 4 cycles after request; a second request skips the CONTROL read (3 cycles).
- RX continuously valid, iTX_REQ held, RX_BURST_MAX=8 → exactly 8 DATA reads, then TX grant; exactly one write per request, none in the ack cycle.
- CONTROL read returns WSPACE=0 → no write, oTX_ACK stays 0, RX resumes; STAT_TX_STALLS=1 with the macro defined.
- WAIT held high 5 cycles during a read → RDREQ and ADDR stable; byte delivered 1 cycle after WAIT falls. iRST asserted mid-wait → all outputs 0 the next cycle.

Source files
------------

// File: rtl/jtag_uart_pkg.sv
// Shared definitions for the JTAG UART slave sequencer: FSM encoding,
// register map and the bit fields used from the UART DATA/CONTROL words.
package jtag_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_DATA = 2'd1,
    ST_RD_CTRL = 2'd2,
    ST_WR_DATA = 2'd3
  } state_t;

  localparam logic JTAG_DATA_ADDR = 1'b0;
  localparam logic JTAG_CTRL_ADDR = 1'b1;

  localparam int RVALID_BIT = 15;
  localparam int WSPACE_LSB = 16;
  localparam int WSPACE_MSB = 31;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/jtag_uart_arb_stats.sv
// Activity counters for the JTAG UART arbiter: delivered RX bytes and
// CONTROL reads that found no write space. Both wrap at 16 bits.
module jtag_uart_arb_stats (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iRX_VALID,
  input  logic        iTX_STALL,
  output logic [15:0] oSTAT_RX_BYTES,
  output logic [15:0] oSTAT_TX_STALLS
);

  logic [15:0] r_rx_bytes;
  logic [15:0] r_tx_stalls;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_rx_bytes  <= 16'd0;
      r_tx_stalls <= 16'd0;
    end else begin
      if (iRX_VALID) r_rx_bytes  <= r_rx_bytes + 16'd1;
      if (iTX_STALL) r_tx_stalls <= r_tx_stalls + 16'd1;
    end
  end

  assign oSTAT_RX_BYTES  = r_rx_bytes;
  assign oSTAT_TX_STALLS = r_tx_stalls;

endmodule

// File: rtl/jtag_uart_arbiter.sv
// Sole master of the JTAG UART Avalon slave: arbitrates RX polling against TX
// writes with WSPACE flow control. Define JTAG_UART_ARB_STATS_EN for counters.
module jtag_uart_arbiter
  import jtag_uart_pkg::*;
#(
  parameter int RX_BURST_MAX = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic        oJTAG_SLAVE_ADDR,
  output logic        oJTAG_SLAVE_RDREQ,
  input  logic [31:0] iJTAG_SLAVE_RDDATA,
  output logic        oJTAG_SLAVE_WRREQ,
  output logic [31:0] oJTAG_SLAVE_WRDATA,
  input  logic        iJTAG_SLAVE_WAIT,
  input  logic        iRX_HOLD,
  output logic [7:0]  oRX_DATA,
  output logic        oRX_VALID,
  input  logic        iTX_REQ,
  input  logic [7:0]  iTX_DATA,
  output logic        oTX_ACK
`ifdef JTAG_UART_ARB_STATS_EN
  ,
  output logic [15:0] oSTAT_RX_BYTES,
  output logic [15:0] oSTAT_TX_STALLS
`endif
);

  localparam logic [7:0] LP_BURST_MAX = 8'(RX_BURST_MAX);

  state_t      r_state;
  logic [7:0]  r_burst_cnt;
  logic [15:0] r_wspace;
  logic [7:0]  r_tx_byte;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_tx_ack;

  state_t      w_state_nxt;
  logic [7:0]  w_burst_nxt;
  logic [15:0] w_wspace_nxt;
  logic [7:0]  w_tx_byte_nxt;
  logic [7:0]  w_rx_data_nxt;
  logic        w_rx_valid_nxt;
  logic        w_tx_ack_nxt;

  logic        w_rx_want;
  logic        w_tx_want;
  logic        w_burst_done;
  logic        w_rvalid;
  logic [15:0] w_rd_wspace;
  logic [6:0]  w_unused_rddata;

  assign w_rx_want    = !iRX_HOLD;
  // Masking with the ack pulse stops a still-high request from being sent twice.
  assign w_tx_want    = iTX_REQ && !r_tx_ack;
  assign w_burst_done = (r_burst_cnt >= LP_BURST_MAX);
  assign w_rvalid     = iJTAG_SLAVE_RDDATA[RVALID_BIT];
  assign w_rd_wspace  = iJTAG_SLAVE_RDDATA[WSPACE_MSB:WSPACE_LSB];
  assign w_unused_rddata = iJTAG_SLAVE_RDDATA[14:8];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_burst_nxt    = r_burst_cnt;
    w_wspace_nxt   = r_wspace;
    w_tx_byte_nxt  = r_tx_byte;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_tx_ack_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tx_want && (!w_rx_want || w_burst_done)) begin
          w_tx_byte_nxt = iTX_DATA;
          w_burst_nxt   = 8'd0;
          w_state_nxt   = (r_wspace != 16'd0) ? ST_WR_DATA : ST_RD_CTRL;
        end else if (w_rx_want) begin
          w_state_nxt = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (!iJTAG_SLAVE_WAIT) begin
          w_rx_data_nxt  = iJTAG_SLAVE_RDDATA[7:0];
          w_rx_valid_nxt = w_rvalid;
          // An empty UART forces the next TX-vs-RX decision in favour of TX.
          w_burst_nxt    = w_rvalid ? sat_inc8(r_burst_cnt) : LP_BURST_MAX;
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_RD_CTRL: begin
        if (!iJTAG_SLAVE_WAIT) begin
          w_wspace_nxt = w_rd_wspace;
          w_state_nxt  = (w_rd_wspace != 16'd0) ? ST_WR_DATA : ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        if (!iJTAG_SLAVE_WAIT) begin
          w_wspace_nxt = r_wspace - 16'd1;
          w_tx_ack_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= 8'd0;
      r_wspace    <= 16'd0;
      r_tx_byte   <= 8'd0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_tx_ack    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_wspace    <= w_wspace_nxt;
      r_tx_byte   <= w_tx_byte_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_tx_ack    <= w_tx_ack_nxt;
    end
  end

  // Bus signals decode purely from the registered state, so they are glitch-free
  // and hold steady for as long as the slave stretches a transfer.
  assign oJTAG_SLAVE_ADDR   = (r_state == ST_RD_CTRL) ? JTAG_CTRL_ADDR : JTAG_DATA_ADDR;
  assign oJTAG_SLAVE_RDREQ  = (r_state == ST_RD_DATA) || (r_state == ST_RD_CTRL);
  assign oJTAG_SLAVE_WRREQ  = (r_state == ST_WR_DATA);
  assign oJTAG_SLAVE_WRDATA = (r_state == ST_WR_DATA) ? {24'd0, r_tx_byte} : 32'd0;

  assign oRX_DATA  = r_rx_data;
  assign oRX_VALID = r_rx_valid;
  assign oTX_ACK   = r_tx_ack;

`ifdef JTAG_UART_ARB_STATS_EN
  logic w_tx_stall;
  assign w_tx_stall = (r_state == ST_RD_CTRL) && !iJTAG_SLAVE_WAIT && (w_rd_wspace == 16'd0);

  jtag_uart_arb_stats u_stats (
    .iCLK            (iCLK),
    .iRST            (iRST),
    .iRX_VALID       (r_rx_valid),
    .iTX_STALL       (w_tx_stall),
    .oSTAT_RX_BYTES  (oSTAT_RX_BYTES),
    .oSTAT_TX_STALLS (oSTAT_TX_STALLS)
  );
`endif

endmodule

// File: tb/tb_jtag_uart_arbiter.sv
// Self-checking bench for jtag_uart_arbiter: a bench-side UART slave model with
// RX/TX scoreboards plus directed checks on cadence, latency, bursts and stalls.
module tb_jtag_uart_arbiter;

  localparam int BURST = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        addr, rdreq, wrreq, wait_r;
  logic [31:0] rddata, wrdata;
  logic        rx_hold, tx_req, rx_valid, tx_ack;
  logic [7:0]  tx_data, rx_data;
  logic [31:0] data_val, ctrl_val;
`ifdef JTAG_UART_ARB_STATS_EN
  logic [15:0] stat_rx, stat_stalls;
`endif

  always #5 clk = ~clk;

  // Slave register model: DATA and CONTROL contents are pure bench stimulus.
  assign rddata = addr ? ctrl_val : data_val;

  jtag_uart_arbiter #(.RX_BURST_MAX(BURST)) dut (
    .iCLK               (clk),
    .iRST               (rst),
    .oJTAG_SLAVE_ADDR   (addr),
    .oJTAG_SLAVE_RDREQ  (rdreq),
    .iJTAG_SLAVE_RDDATA (rddata),
    .oJTAG_SLAVE_WRREQ  (wrreq),
    .oJTAG_SLAVE_WRDATA (wrdata),
    .iJTAG_SLAVE_WAIT   (wait_r),
    .iRX_HOLD           (rx_hold),
    .oRX_DATA           (rx_data),
    .oRX_VALID          (rx_valid),
    .iTX_REQ            (tx_req),
    .iTX_DATA           (tx_data),
    .oTX_ACK            (tx_ack)
`ifdef JTAG_UART_ARB_STATS_EN
    ,
    .oSTAT_RX_BYTES     (stat_rx),
    .oSTAT_TX_STALLS    (stat_stalls)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  rx_q[$];
  logic [31:0] tx_q[$];
  int data_reads = 0, ctrl_reads = 0, writes = 0, acks = 0;
  int valid_pulses = 0, reads_at_write = 0;
  int ctrl_at[4];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Monitor on the falling edge: sees the bus exactly as the next rising edge will.
  always @(negedge clk) begin
    if (!rst) begin
      check("rd_wr_exclusive", {31'd0, rdreq & wrreq}, 32'd0);
      if (rx_valid) begin
        valid_pulses++;
        if (rx_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
        else check("rx_byte", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
      end
      if (rdreq && !wait_r) begin
        if (!addr) begin
          data_reads++;
          if (data_val[15]) rx_q.push_back(data_val[7:0]);
        end else begin
          if (ctrl_reads < 4) ctrl_at[ctrl_reads] = data_reads;
          ctrl_reads++;
        end
      end
      if (wrreq && !wait_r) begin
        writes++;
        reads_at_write = data_reads;
        check("wr_addr", {31'd0, addr}, 32'd0);
        if (tx_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else check("wr_data", wrdata, tx_q.pop_front());
      end
      if (tx_ack) acks++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    valid_pulses = 0;
    data_reads   = 0;
    ctrl_reads   = 0;
    writes       = 0;
    acks         = 0;
  endtask

  task automatic wait_ack(input int budget, output int lat);
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (!tx_ack && lat < budget);
    if (!tx_ack) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rdreq(input int budget);
    int n = 0;
    while (!rdreq && n < budget) begin
      tick(1);
      n++;
    end
    check("rdreq_seen", {31'd0, rdreq}, 32'd1);
  endtask

  initial begin
    int lat;
    int n;
    rst = 1'b1; rx_hold = 1'b1; tx_req = 1'b0; tx_data = 8'd0;
    wait_r = 1'b0; data_val = 32'd0; ctrl_val = 32'd0;

    // Reset state
    tick(3);
    check("rst_rdreq",  {31'd0, rdreq}, 32'd0);
    check("rst_wrreq",  {31'd0, wrreq}, 32'd0);
    check("rst_addr",   {31'd0, addr}, 32'd0);
    check("rst_wrdata", wrdata, 32'd0);
    check("rst_rxvalid", {31'd0, rx_valid}, 32'd0);
    check("rst_rxdata", {24'd0, rx_data}, 32'd0);
    check("rst_txack",  {31'd0, tx_ack}, 32'd0);
    do_reset();
    tick(2);
    check("hold_idle", {31'd0, rdreq}, 32'd0);

    // Continuous valid RX: one byte every second cycle
    data_val = 32'h0000_8041;
    rx_hold  = 1'b0;
    n = 0;
    while (!rx_valid && n < 10) begin tick(1); n++; end
    check("rx_first", {31'd0, rx_valid}, 32'd1);
    check("rx_first_data", {24'd0, rx_data}, 32'h41);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check("rx_cadence", {31'd0, rx_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (rx_valid) data_val = 32'h0000_8000 | 32'(8'h41 + 8'(i));
    end
    rx_hold = 1'b1;
    tick(3);

    // Empty UART: polling continues, nothing delivered
    data_val = 32'h0000_00EE;
    rx_hold = 1'b0;
    data_reads = 0;
    n = valid_pulses;
    tick(8);
    check("empty_polls", (data_reads >= 3) ? 32'd1 : 32'd0, 32'd1);
    check("empty_no_valid", 32'(valid_pulses - n), 32'd0);
    rx_hold = 1'b1;
    tick(2);

    // TX needing a CONTROL read, then a TX served from cached WSPACE
    ctrl_val = 32'h0040_0000;
    ctrl_reads = 0; writes = 0; acks = 0;
    tx_data = 8'h5A; tx_q.push_back(32'h0000_005A); tx_req = 1'b1;
    wait_ack(20, lat);
    check("tx_lat_ctrl", 32'(lat + 1), 32'd4);
    tick(1);
    tx_req = 1'b0;
    tick(2);
    check("tx1_ctrl_reads", 32'(ctrl_reads), 32'd1);
    check("tx1_writes", 32'(writes), 32'd1);
    check("tx1_acks", 32'(acks), 32'd1);

    ctrl_reads = 0; writes = 0;
    tx_data = 8'hC3; tx_q.push_back(32'h0000_00C3); tx_req = 1'b1;
    wait_ack(20, lat);
    check("tx_lat_cached", 32'(lat + 1), 32'd3);
    tick(1);
    tx_req = 1'b0;
    tick(2);
    check("tx2_ctrl_reads", 32'(ctrl_reads), 32'd0);
    check("tx2_writes", 32'(writes), 32'd1);

    // RX burst limit while TX is pending
    data_val = 32'h0000_8012;
    data_reads = 0; writes = 0;
    tx_data = 8'h77; tx_q.push_back(32'h0000_0077);
    rx_hold = 1'b0; tx_req = 1'b1;
    wait_ack(60, lat);
    check("burst_reads", 32'(reads_at_write), 32'(BURST));
    tick(1);
    tx_req = 1'b0; rx_hold = 1'b1;
    tick(4);
    check("burst_writes", 32'(writes), 32'd1);

    // WSPACE = 0: no write, RX gets a full burst between CONTROL retries
    do_reset();
    ctrl_val = 32'h0000_0000;
    data_val = 32'h0000_8033;
    tx_data = 8'h11; tx_q.push_back(32'h0000_0011);
    tx_req = 1'b1; rx_hold = 1'b0;
    tick(45);
    check("stall_writes", 32'(writes), 32'd0);
    check("stall_acks", 32'(acks), 32'd0);
    check("stall_retries", (ctrl_reads >= 2) ? 32'd1 : 32'd0, 32'd1);
    check("stall_rx_gap", 32'(ctrl_at[1] - ctrl_at[0]), 32'(BURST));
    check("stall_rx_resumes", (valid_pulses >= 2 * BURST) ? 32'd1 : 32'd0, 32'd1);
`ifdef JTAG_UART_ARB_STATS_EN
    check("stat_tx_stalls", {16'd0, stat_stalls}, 32'(ctrl_reads));
    check("stat_rx_bytes", {16'd0, stat_rx}, 32'(valid_pulses));
`endif
    ctrl_val = 32'h0001_0000;
    wait_ack(40, lat);
    tick(1);
    tx_req = 1'b0; rx_hold = 1'b1;
    tick(4);
    check("unstall_writes", 32'(writes), 32'd1);

    // WAIT held during a read; hold rising mid-read must not drop the byte
    data_val = 32'h0000_80C7;
    wait_r = 1'b1; rx_hold = 1'b0;
    wait_rdreq(5);
    rx_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("wait_rdreq", {31'd0, rdreq}, 32'd1);
      check("wait_addr", {31'd0, addr}, 32'd0);
      check("wait_novalid", {31'd0, rx_valid}, 32'd0);
    end
    wait_r = 1'b0;
    tick(1);
    check("wait_valid", {31'd0, rx_valid}, 32'd1);
    check("wait_data", {24'd0, rx_data}, 32'hC7);
    tick(2);
    check("wait_hold_idle", {31'd0, rdreq}, 32'd0);

    // Reset in the middle of a stretched read
    wait_r = 1'b1; rx_hold = 1'b0;
    wait_rdreq(5);
    rx_hold = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    check("mid_rst_rdreq", {31'd0, rdreq}, 32'd0);
    check("mid_rst_wrreq", {31'd0, wrreq}, 32'd0);
    check("mid_rst_addr", {31'd0, addr}, 32'd0);
    check("mid_rst_rxvalid", {31'd0, rx_valid}, 32'd0);
    check("mid_rst_txack", {31'd0, tx_ack}, 32'd0);
    rst = 1'b0; wait_r = 1'b0;
    tick(3);

    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
